tx_frame_arbiter: RTL and testbench

- Shares the single par8/uart transmit port between NUM_REQ byte-stream requesters, e.g. cmd_parser responses and a status/heartbeat reporter.
- Grants the port per frame and holds the grant until the owner releases it, so frames never interleave.
- Round-robin fairness between frames; watchdog revokes a stalled owner; a programmable gap separates consecutive frames.

---
 rtl/tx_frame_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares one byte-wide transmit port (txd_*) between NUM_REQ
// byte-stream requesters. The port is granted per frame and held until the owner
// drops req, so frames never interleave. Arbitration is round-robin per frame. A
// watchdog revokes an owner that stops sending, and GAP_CYCLES dead cycles follow
// every frame.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   req             per-requester frame request, held for the whole frame
//   req_start       per-requester byte strobe
//   req_data        per-requester byte, requester i on [8i+7:8i]
//   req_ready_next  txd_ready_next routed to the owner only
//   grant           one-hot owner, 0 when nobody owns the port
//   txd_ready_next  transmitter ready (input)
//   txd_start       byte strobe to transmitter (registered)
//   txd_data        byte to transmitter (registered)
//   frame_abort     one-cycle pulse when the watchdog revokes a grant
//   drop_err        one-cycle pulse when a non-owner strobes a byte
//   busy            state is GRANT or GAP
//   led             {state[1:0], owner index[2:0], rr pointer[2:0]}
module tx_frame_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_start,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready_next,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 txd_ready_next,
  output logic                 txd_start,
  output logic [7:0]           txd_data,
  output logic                 frame_abort,
  output logic                 drop_err,
  output logic                 busy,
  output logic [7:0]           led
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         rr_q, rr_d;
  logic [CntW-1:0]    idle_q, idle_d;
  logic [7:0]         gap_q, gap_d;
  logic [NUM_REQ-1:0] stale_q, stale_d;
  logic               txd_start_q, txd_start_d;
  logic [7:0]         txd_data_q, txd_data_d;
  logic               frame_abort_q, frame_abort_d;
  logic               drop_err_q, drop_err_d;

  // Owner view: grant_q is one-hot (or zero), so masking selects the owner's lane.
  logic               own_req;
  logic               own_start;
  logic [7:0]         own_data;

  assign own_req   = |(req & grant_q);
  assign own_start = |(req_start & grant_q);

  always_comb begin
    own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) own_data = own_data | req_data[8*i +: 8];
    end
  end

  // Round-robin pick starting at rr_q; stale (watchdog-aborted) requesters are skipped.
  logic [NUM_REQ-1:0] elig;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [2:0]         cand;

  assign elig = req & ~stale_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = 3'((32'(rr_q) + j) % NUM_REQ);
      if (!pick_found && elig[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic [31:0] idle_inc;
  logic [2:0]  next_ptr;

  assign idle_inc = 32'(idle_q) + 32'd1;
  assign next_ptr = 3'((32'(idx_q) + 32'd1) % NUM_REQ);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    idle_d        = idle_q;
    gap_d         = gap_q;
    stale_d       = stale_q & req;  // a stale flag clears once its req drops
    txd_start_d   = 1'b0;
    txd_data_d    = txd_data_q;
    frame_abort_d = 1'b0;
    // Every strobe outside the owner lane is discarded; one pulse covers all of them.
    drop_err_d    = |(req_start & ~grant_q);

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (32'(pick_idx) == i);
          end
          idx_d   = pick_idx;
          idle_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (own_start) begin
          txd_start_d = 1'b1;
          txd_data_d  = own_data;
          idle_d      = '0;
        end else begin
          idle_d = idle_inc[CntW-1:0];
        end
        // A byte strobed in the same cycle req drops is still forwarded above.
        if (!own_req) begin
          grant_d = '0;
          rr_d    = next_ptr;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (!own_start && (TIMEOUT != 0) && (idle_inc == TIMEOUT)) begin
          frame_abort_d = 1'b1;
          stale_d       = stale_d | grant_q;
          grant_d       = '0;
          rr_d          = next_ptr;
          idle_d        = '0;
          gap_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        gap_d = gap_q + 8'd1;
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
          gap_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      idx_q         <= '0;
      rr_q          <= '0;
      idle_q        <= '0;
      gap_q         <= '0;
      stale_q       <= '0;
      txd_start_q   <= 1'b0;
      txd_data_q    <= '0;
      frame_abort_q <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      idx_q         <= idx_d;
      rr_q          <= rr_d;
      idle_q        <= idle_d;
      gap_q         <= gap_d;
      stale_q       <= stale_d;
      txd_start_q   <= txd_start_d;
      txd_data_q    <= txd_data_d;
      frame_abort_q <= frame_abort_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign grant          = grant_q;
  assign req_ready_next = grant_q & {NUM_REQ{txd_ready_next}};
  assign txd_start      = txd_start_q;
  assign txd_data       = txd_data_q;
  assign frame_abort    = frame_abort_q;
  assign drop_err       = drop_err_q;
  assign busy           = (state_q != StIdle);
  assign led            = {state_q, idx_q, rr_q};

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter (NUM_REQ=2, TIMEOUT=16, GAP_CYCLES=4).
module tb_tx_frame_arbiter;

  localparam int unsigned GapCycles = 4;
  localparam int unsigned Timeout   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_start;
  logic [15:0] req_data;
  logic [1:0]  req_ready_next;
  logic [1:0]  grant;
  logic        txd_ready_next;
  logic        txd_start;
  logic [7:0]  txd_data;
  logic        frame_abort;
  logic        drop_err;
  logic        busy;
  logic [7:0]  led;

  int n_cmp  = 0;
  int n_fail = 0;

  tx_frame_arbiter #(
    .NUM_REQ   (2),
    .TIMEOUT   (Timeout),
    .GAP_CYCLES(GapCycles)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_start     (req_start),
    .req_data      (req_data),
    .req_ready_next(req_ready_next),
    .grant         (grant),
    .txd_ready_next(txd_ready_next),
    .txd_start     (txd_start),
    .txd_data      (txd_data),
    .frame_abort   (frame_abort),
    .drop_err      (drop_err),
    .busy          (busy),
    .led           (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  start;
    logic [15:0] data;
    logic        rdy;
    logic [1:0]  e_grant;
    logic        e_start;
    logic [7:0]  e_data;
    logic        e_drop;
    logic        e_abort;
    logic        e_busy;
    logic [1:0]  e_rnext;
    logic [7:0]  e_led;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] r, input logic [1:0] s, input logic [15:0] d,
                     input logic rdy, input logic [1:0] g, input logic st,
                     input logic [7:0] td, input logic dr, input logic ab, input logic bz,
                     input logic [1:0] rn, input logic [7:0] ld);
    vec_t v;
    v.req = r; v.start = s; v.data = d; v.rdy = rdy;
    v.e_grant = g; v.e_start = st; v.e_data = td; v.e_drop = dr; v.e_abort = ab;
    v.e_busy = bz; v.e_rnext = rn; v.e_led = ld;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps until a grant appears; cnt is the number of edges taken.
  task automatic wait_grant(input string name, output int cnt);
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (grant != 2'b00) begin
        cnt = k;
        break;
      end
    end
    if (cnt == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no grant within 30 cycles, got grant 0x%0h", name, grant);
    end
  endtask

  initial begin
    int        cnt;
    logic [1:0] exp_g;
    logic [7:0] byte_v;
    int        o;
    int        seen;

    reset = 1'b1; req = '0; req_start = '0; req_data = '0; txd_ready_next = 1'b1;
    step();
    step();
    check("reset grant", 32'(grant), 0);
    check("reset txd_start", 32'(txd_start), 0);
    check("reset txd_data", 32'(txd_data), 0);
    check("reset abort", 32'(frame_abort), 0);
    check("reset drop", 32'(drop_err), 0);
    check("reset busy", 32'(busy), 0);
    check("reset led", 32'(led), 0);
    reset = 1'b0;

    //   req    start  data      rdy   grant st  data   drp ab bsy rnext led
    add(2'b01, 2'b00, 16'h0000, 1'b1, 2'b01, 1, 8'h00, 0, 0, 1, 2'b01, 8'h40) ;
    vq[$].e_start = 1'b0;
    add(2'b01, 2'b01, 16'h00A1, 1'b1, 2'b01, 1, 8'hA1, 0, 0, 1, 2'b01, 8'h40);
    add(2'b01, 2'b01, 16'h00A2, 1'b1, 2'b01, 1, 8'hA2, 0, 0, 1, 2'b01, 8'h40);
    add(2'b01, 2'b00, 16'h0000, 1'b1, 2'b01, 0, 8'hA2, 0, 0, 1, 2'b01, 8'h40);
    add(2'b01, 2'b01, 16'h00A3, 1'b1, 2'b01, 1, 8'hA3, 0, 0, 1, 2'b01, 8'h40);
    // Frame end, four GAP cycles, then IDLE with rr pointer 1.
    add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hA3, 0, 0, 1, 2'b00, 8'h81);
    for (int i = 0; i < 3; i++)
      add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hA3, 0, 0, 1, 2'b00, 8'h81);
    add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hA3, 0, 0, 0, 2'b00, 8'h01);
    // Last byte strobed in the same cycle req drops.
    add(2'b01, 2'b00, 16'h0000, 1'b1, 2'b01, 0, 8'hA3, 0, 0, 1, 2'b01, 8'h41);
    add(2'b00, 2'b01, 16'h00B7, 1'b1, 2'b00, 1, 8'hB7, 0, 0, 1, 2'b00, 8'h81);
    for (int i = 0; i < 3; i++)
      add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hB7, 0, 0, 1, 2'b00, 8'h81);
    add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hB7, 0, 0, 0, 2'b00, 8'h01);
    // Non-owner injection while requester 0 owns the port.
    add(2'b01, 2'b00, 16'h0000, 1'b1, 2'b01, 0, 8'hB7, 0, 0, 1, 2'b01, 8'h41);
    add(2'b01, 2'b10, 16'h5500, 1'b1, 2'b01, 0, 8'hB7, 1, 0, 1, 2'b01, 8'h41);
    add(2'b01, 2'b01, 16'h00C3, 1'b1, 2'b01, 1, 8'hC3, 0, 0, 1, 2'b01, 8'h41);
    add(2'b01, 2'b00, 16'h0000, 1'b0, 2'b01, 0, 8'hC3, 0, 0, 1, 2'b00, 8'h41);
    add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hC3, 0, 0, 1, 2'b00, 8'h81);
    for (int i = 0; i < 3; i++)
      add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hC3, 0, 0, 1, 2'b00, 8'h81);
    add(2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 0, 8'hC3, 0, 0, 0, 2'b00, 8'h01);

    foreach (vq[i]) begin
      req = vq[i].req; req_start = vq[i].start; req_data = vq[i].data;
      txd_ready_next = vq[i].rdy;
      step();
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(vq[i].e_grant));
      check($sformatf("vec%0d txd_start", i), 32'(txd_start), 32'(vq[i].e_start));
      check($sformatf("vec%0d txd_data", i), 32'(txd_data), 32'(vq[i].e_data));
      check($sformatf("vec%0d drop_err", i), 32'(drop_err), 32'(vq[i].e_drop));
      check($sformatf("vec%0d frame_abort", i), 32'(frame_abort), 32'(vq[i].e_abort));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      check($sformatf("vec%0d req_ready_next", i), 32'(req_ready_next), 32'(vq[i].e_rnext));
      check($sformatf("vec%0d led", i), 32'(led), 32'(vq[i].e_led));
    end
    req_start = '0; req_data = '0; txd_ready_next = 1'b1;

    // Reset in the middle of a frame with a strobe pending.
    req = 2'b01;
    step();
    check("midreset pre grant", 32'(grant), 32'h1);
    req_start = 2'b01; req_data = 16'h00D4; reset = 1'b1;
    step();
    check("midreset grant", 32'(grant), 0);
    check("midreset txd_start", 32'(txd_start), 0);
    check("midreset txd_data", 32'(txd_data), 0);
    check("midreset abort", 32'(frame_abort), 0);
    check("midreset led", 32'(led), 0);
    reset = 1'b0; req = '0; req_start = '0; req_data = '0;
    step();

    // Contention: both requesting, grants alternate 0,1,0,1.
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      o = f % 2;
      exp_g = (o == 0) ? 2'b01 : 2'b10;
      wait_grant($sformatf("rr frame%0d wait", f), cnt);
      check($sformatf("rr frame%0d grant", f), 32'(grant), 32'(exp_g));
      check($sformatf("rr frame%0d latency", f), 32'(cnt), (f == 0) ? 1 : GapCycles + 1);
      check($sformatf("rr frame%0d ready_next", f), 32'(req_ready_next), 32'(exp_g));
      for (int b = 0; b < 2; b++) begin
        byte_v = 8'(8'h10 * (f + 1) + b);
        req_start = exp_g;
        req_data = (o == 0) ? {8'h00, byte_v} : {byte_v, 8'h00};
        step();
        check($sformatf("rr frame%0d byte%0d start", f, b), 32'(txd_start), 1);
        check($sformatf("rr frame%0d byte%0d data", f, b), 32'(txd_data), 32'(byte_v));
      end
      req_start = '0; req_data = '0;
      req = 2'b11 & ~exp_g;
      step();
      check($sformatf("rr frame%0d end grant", f), 32'(grant), 0);
      check($sformatf("rr frame%0d rr_ptr", f), 32'(led[2:0]), 32'((o + 1) % 2));
      req = 2'b11;
    end

    // Watchdog: owner 0 holds req without strobes.
    wait_grant("wd wait", cnt);
    check("wd grant", 32'(grant), 32'h1);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (frame_abort) begin
        cnt = k;
        break;
      end
    end
    check("wd abort cycle", 32'(cnt), Timeout);
    check("wd grant revoked", 32'(grant), 0);
    check("wd rr_ptr", 32'(led[2:0]), 1);
    step();
    check("wd abort pulse width", 32'(frame_abort), 0);
    wait_grant("wd next wait", cnt);
    check("wd next grant", 32'(grant), 32'h2);
    req_start = 2'b10; req_data = 16'h7700;
    step();
    check("wd req1 data", 32'(txd_data), 32'h77);
    req_start = '0; req_data = '0;
    req = 2'b01;
    step();
    check("wd req1 end grant", 32'(grant), 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (grant != 2'b00) seen++;
    end
    check("wd stale not regranted", 32'(seen), 0);
    req = 2'b00;
    step();
    req = 2'b01;
    wait_grant("wd regrant wait", cnt);
    check("wd regrant after drop", 32'(grant), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
